// File: rtl/mips_pkg.sv
`default_nettype none
// mips_pkg: shared shift-op and shift FSM state encodings.
// Rev 1.0
package mips_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL  = 2'b00,
        SHIFT_SRL  = 2'b01,
        SHIFT_SRA  = 2'b10,
        SHIFT_PASS = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } shift_state_e;

endpackage
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// shift_step: combinational single step of 1 or 2 bit positions, left or right.
// Rev 1.0
module shift_step
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic             step2_i,
    input  logic             dir_right_i,
    input  logic             arith_i,
    output logic [WIDTH-1:0] value_o
);

    logic fill;

    // The sign bit never moves during SRA, so the current MSB is the original one.
    assign fill = arith_i & value_i[WIDTH-1];

    always_comb begin
        value_o = value_i;
        if (dir_right_i) begin
            if (step2_i) begin
                value_o = {{2{fill}}, value_i[WIDTH-1:2]};
            end else begin
                value_o = {fill, value_i[WIDTH-1:1]};
            end
        end else begin
            if (step2_i) begin
                value_o = {value_i[WIDTH-3:0], 2'b00};
            end else begin
                value_o = {value_i[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/shift_unit.sv
`default_nettype none
// shift_unit: multi-cycle SLL/SRL/SRA unit retiring up to 2 bit positions per clock.
// Rev 1.0
module shift_unit
    import mips_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   operand,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    shift_state_e       state_q;
    shift_op_e          op_q;
    logic [WIDTH-1:0]   work_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic [WIDTH-1:0]   result_q;
    logic               busy_q;
    logic               done_q;

    logic               step2;
    logic [WIDTH-1:0]   work_d;
    logic [SHAMT_W-1:0] cnt_d;

    assign step2 = (cnt_q >= SHAMT_W'(2));
    assign cnt_d = cnt_q - (step2 ? SHAMT_W'(2) : SHAMT_W'(1));

    shift_step #(
        .WIDTH (WIDTH)
    ) u_shift_step (
        .value_i     (work_q),
        .step2_i     (step2),
        .dir_right_i (op_q != SHIFT_SLL),
        .arith_i     (op_q == SHIFT_SRA),
        .value_o     (work_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= SHIFT_SLL;
            work_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        work_q <= operand;
                        op_q   <= shift_op_e'(op);
                        cnt_q  <= shamt;
                        busy_q <= 1'b1;
                        // Nothing to shift: publish the operand directly.
                        if (shamt == '0 || shift_op_e'(op) == SHIFT_PASS) begin
                            result_q <= operand;
                            state_q  <= ST_DONE;
                            done_q   <= 1'b1;
                        end else begin
                            state_q  <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_d;
                    if (cnt_d == '0) begin
                        result_q <= work_d;
                        state_q  <= ST_DONE;
                        done_q   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
`default_nettype wire

// File: doc/shift_unit.md
SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: data width in bits.
REQ-002 The block SHALL have parameter SHAMT_W, default 5: shift-amount width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: request a shift; sampled only in IDLE.
REQ-006 The block SHALL have port op, input, 2 bits: 00 SLL, 01 SRL, 10 SRA, 11 reserved (pass-through).
REQ-007 The block SHALL have port operand, input, WIDTH bits: value to shift.
REQ-008 The block SHALL have port shamt, input, SHAMT_W bits: shift amount, unsigned.
REQ-009 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse; result valid.
REQ-011 The block SHALL have port result, output, WIDTH bits: registered shift result.

Function
REQ-012 The FSM SHALL have the states IDLE, SHIFT and DONE, with busy = (state != IDLE) and done = (state == DONE).
REQ-013 In IDLE with start=1, the FSM SHALL latch operand, op and shamt at the same edge (edge 0).
REQ-014 At edge 0 the FSM SHALL go to DONE when shamt==0 or op==11, and to SHIFT otherwise.
REQ-015 In SHIFT, each edge SHALL shift the working register by 2 when the remaining count is 2 or more, and by 1 otherwise, then decrement the count by the same amount.
REQ-016 The edge at which the remaining count reaches 0 SHALL also move the FSM from SHIFT to DONE.
REQ-017 Latency SHALL be N = ceil(shamt/2) SHIFT edges, with done high in the cycle after edge N (edge 0 when N=0).
REQ-018 SLL SHALL fill with 0 at the LSB; SRL SHALL fill with 0 at the MSB; SRA SHALL fill with the operand MSB latched at edge 0.
REQ-019 For op==11 the result SHALL equal operand unchanged.
REQ-020 The result SHALL be truncated to WIDTH bits; bits shifted out are discarded.
REQ-021 DONE SHALL last exactly one cycle, then the FSM SHALL return to IDLE unconditionally.
REQ-022 start SHALL be ignored in SHIFT and DONE, so a new request is accepted no earlier than the cycle after done.
REQ-023 result SHALL hold its last value from DONE until the next DONE, and SHALL be unchanged during SHIFT.
REQ-024 The inputs operand, op and shamt SHALL have no effect after edge 0 of an operation.

Reset
REQ-025 With rst_n=0 at a clock edge, the block SHALL force state=IDLE, result=0, busy=0, done=0, and working register and count to 0.
REQ-026 A reset during SHIFT or DONE SHALL abort the operation with no done pulse, and the aborted result SHALL never appear.
REQ-027 start SHALL be ignored at any edge where rst_n=0.

Structure
REQ-028 The shared package mips_pkg SHALL hold the op encodings (SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_PASS) and the FSM state encoding.
REQ-029 A combinational sub-module shift_step SHALL be instantiated once; it takes the value, the step (1 or 2), the direction and the arithmetic flag, and returns the stepped value.
REQ-030 The FSM, count and registers SHALL reside in shift_unit.

Verification
REQ-031 SLL, operand 0x00000001, shamt 31 -> result 0x80000000; done after edge 16; busy high for 17 cycles.
REQ-032 SRA, operand 0x80000000, shamt 4 -> result 0xF8000000 after edge 2; SRL with the same inputs -> 0x08000000.
REQ-033 SRL, operand 0xFFFFFFFF, shamt 3 (steps 2 then 1) -> result 0x1FFFFFFF; done after edge 2.
REQ-034 shamt 0 or op 11, operand 0x12345678 -> result 0x12345678; done in the cycle after edge 0.
REQ-035 A second start with operand 0xDEADBEEF during SHIFT -> ignored; the first result is unaffected; one done pulse only.
REQ-036 rst_n=0 at edge 3 of an SLL with shamt 20 -> next cycle busy=0, done=0, result=0; no done pulse follows.
